// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed access latency
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall,
  output logic        misaligned_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t             state, state_nx;
  logic [3:0]         cnt;
  logic               we_q;
  logic [3:0]         wmask_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [1:0]         off_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [2**ADDR_W];
  logic               accept, fire, aligned;
  logic               unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign accept      = state == IDLE && req_valid;
  assign fire        = state == WAIT && cnt == 4'd0;
  assign aligned     = off_q == 2'd0;
  assign req_ready      = state == IDLE;
  assign resp_valid     = state == RESP;
  assign misaligned_err = state == RESP && !aligned;
  assign stall          = (accept && rst) || state == WAIT;
  // state register; reset drops any pending access
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  // next state: accept in IDLE, count down in WAIT, RESP lasts one cycle
  always_comb
    state_nx = state == IDLE ? (req_valid ? WAIT : IDLE) :
               state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  // request capture and latency counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      we_q    <= req_we;
      wmask_q <= req_wmask;
      idx_q   <= req_addr[ADDR_W+1:2];
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  // load data is valid only in the RESP cycle, zero otherwise
  always_ff @(posedge clk or negedge rst)
    if (!rst) resp_rdata <= '0;
    else      resp_rdata <= (fire && !we_q && aligned) ? mem[idx_q] : '0;
  // byte-masked store commit on the WAIT->RESP edge; contents survive reset
  always_ff @(posedge clk)
    if (fire && we_q && aligned)
      for (int b = 0; b < 4; b++)
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the data-memory responder
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_wmask = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, stall, misaligned_err;
  logic [31:0] resp_rdata;
  int          total = 0;
  int          bad = 0;

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .stall(stall), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  // one access: lat = edges from acceptance to RESP, st = stall cycles,
  // ok = response lasted one cycle and rdata returned to zero afterwards
  task automatic access(input logic we, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output int st, output logic ok);
    lat = 0; st = 0; rd = '0; er = 1'b0; ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    #1 st += int'(stall);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_wmask = 4'hF; req_addr = '1; req_wdata = '1;
    #1;
    while (!resp_valid && lat < 20) begin
      st += int'(stall);
      lat++;
      @(negedge clk);
      #1;
    end
    rd = resp_rdata; er = misaligned_err; st += int'(stall);
    @(negedge clk);
    #1 ok = !resp_valid && resp_rdata == 32'h0 && !misaligned_err && req_ready;
    req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    #3;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (misaligned_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", misaligned_err); end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    int lat, st; logic [31:0] rd; logic er, ok;
    access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er, st, ok);
    total++; if (lat !== 2) begin bad++; $display("FAIL st_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL st_rdata got=%h exp=0", rd); end
    total++; if (st !== 3) begin bad++; $display("FAIL st_stall_cycles got=%0d exp=3", st); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL st_err got=%b exp=0", er); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL st_one_cycle got=%b exp=1", ok); end
    access(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, st, ok);
    total++; if (lat !== 2) begin bad++; $display("FAIL ld_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
    total++; if (st !== 3) begin bad++; $display("FAIL ld_stall_cycles got=%0d exp=3", st); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ld_one_cycle got=%b exp=1", ok); end
  endtask

  task automatic test_byte_mask();
    int lat, st; logic [31:0] rd; logic er, ok;
    access(1'b1, 4'hF, 32'h14, 32'h11223344, lat, rd, er, st, ok);
    access(1'b1, 4'h1, 32'h14, 32'h000000AA, lat, rd, er, st, ok);
    access(1'b0, 4'h0, 32'h14, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'h112233AA) begin bad++; $display("FAIL mask_byte0 got=%h exp=112233aa", rd); end
    access(1'b1, 4'h0, 32'h14, 32'hFFFFFFFF, lat, rd, er, st, ok);
    access(1'b0, 4'h0, 32'h14, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'h112233AA) begin bad++; $display("FAIL mask_zero got=%h exp=112233aa", rd); end
    access(1'b1, 4'h6, 32'h14, 32'h55667788, lat, rd, er, st, ok);
    access(1'b0, 4'h0, 32'h14, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'h116677AA) begin bad++; $display("FAIL mask_mid got=%h exp=116677aa", rd); end
  endtask

  task automatic test_misaligned();
    int lat, st; logic [31:0] rd; logic er, ok;
    access(1'b0, 4'h0, 32'h13, 32'h0, lat, rd, er, st, ok);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_ld_err got=%b exp=1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_ld_rdata got=%h exp=0", rd); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mis_ld_idle got=%b exp=1", ok); end
    access(1'b1, 4'hF, 32'h11, 32'h0, lat, rd, er, st, ok);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_st_err got=%b exp=1", er); end
    access(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_st_nowrite got=%h exp=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_aligned_err got=%b exp=0", er); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] rdy, rv, stl;
    logic [31:0] rd3, rd4, rd7;
    rd3 = '0; rd4 = '0; rd7 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_wmask = '0; req_addr = 32'h10;
    for (int i = 0; i < 9; i++) begin
      #1;
      rdy[i] = req_ready; rv[i] = resp_valid; stl[i] = stall;
      if (i == 3) begin rd3 = resp_rdata; req_addr = 32'h14; end
      if (i == 4) rd4 = resp_rdata;
      if (i == 7) begin rd7 = resp_rdata; req_valid = 1'b0; end
      @(negedge clk);
    end
    req_addr = '0;
    total++; if (rdy !== 9'b100010001) begin bad++; $display("FAIL b2b_ready got=%b exp=100010001", rdy); end
    total++; if (rv !== 9'b010001000) begin bad++; $display("FAIL b2b_resp_valid got=%b exp=010001000", rv); end
    total++; if (stl !== 9'b001110111) begin bad++; $display("FAIL b2b_stall got=%b exp=001110111", stl); end
    total++; if (rd3 !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_rdata1 got=%h exp=deadbeef", rd3); end
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL b2b_rdata_idle got=%h exp=0", rd4); end
    total++; if (rd7 !== 32'h116677AA) begin bad++; $display("FAIL b2b_rdata2 got=%h exp=116677aa", rd7); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, st; logic [31:0] rd; logic er, ok;
    access(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, lat, rd, er, st, ok);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rw_stall_before got=%b exp=1", stall); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b exp=1", req_ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rw_stall got=%b exp=0", stall); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rw_resp_valid got=%b exp=0", resp_valid); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL rw_mem_kept got=%h exp=cafef00d", rd); end
    total++; if (lat !== 2) begin bad++; $display("FAIL rw_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_wrap();
    int lat, st; logic [31:0] rd; logic er, ok;
    access(1'b1, 4'hF, 32'h0, 32'hA5A50001, lat, rd, er, st, ok);
    access(1'b0, 4'h0, 32'h400, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'hA5A50001) begin bad++; $display("FAIL wrap_load got=%h exp=a5a50001", rd); end
    access(1'b1, 4'hF, 32'h404, 32'h0BADF00D, lat, rd, er, st, ok);
    access(1'b0, 4'h0, 32'h4, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL wrap_store got=%h exp=0badf00d", rd); end
    access(1'b1, 4'hF, 32'h3FC, 32'h00000077, lat, rd, er, st, ok);
    access(1'b0, 4'h0, 32'hFFFFFFFC, 32'h0, lat, rd, er, st, ok);
    total++; if (rd !== 32'h00000077) begin bad++; $display("FAIL wrap_top got=%h exp=00000077", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_mask();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, word-address width, giving a memory depth of 2^ADDR_W 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, wait cycles from acceptance to response, legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  MEM-stage access request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_wmask  input  4  byte strobes for stores; bit i enables byte i.
REQ-008 req_addr  input  32  byte address (ALU effective address).
REQ-009 req_wdata  input  32  store data.
REQ-010 req_ready  output  1  request may be accepted this cycle.
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_rdata  output  32  load data, driven to the MEM/WB latch data input.
REQ-013 stall  output  1  holds pipeline-register enables low while an access is outstanding.
REQ-014 misaligned_err  output  1  one-cycle pulse flagging a non-word-aligned request.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; the block SHALL hold at most one outstanding request.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur at the edge where req_valid=1 in IDLE, latching we, wmask, addr, wdata, loading counter with LATENCY-1, and entering WAIT.
REQ-018 In WAIT, a zero counter SHALL cause RESP at the next edge; otherwise the counter SHALL decrement at the next edge.
REQ-019 Acceptance at edge E0 SHALL yield resp_valid=1 for exactly the one cycle following edge E(LATENCY).
REQ-020 The word index SHALL be latched addr[ADDR_W+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo depth.
REQ-021 Load data SHALL be read and registered into resp_rdata on the WAIT->RESP edge.
REQ-022 Store bytes SHALL be committed on the WAIT->RESP edge.
REQ-023 Only bytes whose wmask bit is 1 SHALL be written; wmask=0 SHALL leave memory unchanged.
REQ-024 resp_rdata SHALL be 0 for stores.
REQ-025 resp_rdata SHALL be 0 in every cycle outside RESP.
REQ-026 If latched addr[1:0]!=0, memory SHALL be neither read nor written, resp_rdata SHALL be 0, and misaligned_err SHALL be 1 in the RESP cycle only.
REQ-027 stall SHALL equal (state==IDLE and req_valid) or state==WAIT.
REQ-028 stall SHALL be 0 in RESP, so the pipeline latch captures resp_rdata on the RESP->IDLE edge.
REQ-029 Inputs SHALL be ignored in WAIT and RESP; req_valid deasserting mid-access SHALL NOT cancel the latched request.
REQ-030 RESP SHALL always return to IDLE.
REQ-031 A request held in RESP SHALL NOT be accepted; a request still asserted in the following IDLE cycle SHALL be accepted as new.
REQ-032 A counter value outside WAIT SHALL have no effect.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, stall=0, misaligned_err=0, regardless of clk.
REQ-034 Reset during WAIT SHALL discard the pending access; no memory write SHALL occur.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Leaving reset SHALL require rst=1 before the first acceptance edge; the first edge with rst=1 and req_valid=1 SHALL accept.

Verification
REQ-037 Store 0xDEADBEEF at 0x10, wmask=0xF, LATENCY=2, then load 0x10 -> store resp_valid after E2 with rdata 0; load rdata 0xDEADBEEF, stall high for exactly 3 cycles per access.
REQ-038 Store 0x000000AA wmask=0x1 to a word holding 0x11223344 -> subsequent load returns 0x112233AA.
REQ-039 Load 0x13 -> misaligned_err=1 and rdata=0 in RESP; memory unchanged; FSM returns to IDLE.
REQ-040 req_valid held high continuously for two loads -> second acceptance one cycle after RESP, never during RESP; each resp_valid exactly one cycle.
REQ-041 rst pulsed low mid-WAIT of a store to 0x20 -> outputs zero asynchronously; later load 0x20 returns the prior contents.
REQ-042 Load 0x400 with ADDR_W=8 -> returns the word at address 0x000 (wrap).
